maj_net_eval: RTL and testbench
===============================

Name: maj_net_eval

Overview:
- Programmable, sequential evaluator for majority-of-three gate networks over NUM_IN primary inputs.
- A node table is loaded through a config port. Each input vector is then evaluated one node per cycle, with a valid/ready handshake on both input and output.
- Generalises the fixed 7-input majority netlists in this library: inputs, node count and complemented edges are all runtime/parametric.

Parameters:
- NUM_IN, 7, number of primary inputs (2..16).
- NUM_NODES, 8, node table depth (1..64).
- SEL_W, clog2(NUM_IN+NUM_NODES+1), operand select width (derived; do not override).
- LEN_W, clog2(NUM_NODES+1), width of program length.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_we  in  1  node table write strobe.
- cfg_addr  in  clog2(NUM_NODES)  node index to write.
- cfg_data  in  3*(SEL_W+1)  three operands; each operand is {inv, sel}; operand A is in the LSBs.
- cfg_err  out  1  one-cycle pulse: write rejected.
- in_valid  in  1  input vector offered.
- in_ready  out  1  block can accept a vector.
- in_x  in  NUM_IN  primary input vector.
- in_len  in  LEN_W  number of nodes to evaluate; sampled at accept.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_bit  out  1  value of node in_len-1; 0 if in_len==0.

Behaviour:
- Operand sel encoding:
  - 0 = constant 0.
  - 1..NUM_IN = in_x[sel-1].
  - NUM_IN+1..NUM_IN+NUM_NODES = node[sel-NUM_IN-1] result.
  - Any other sel value reads 0.
  - inv=1 complements the operand after selection, so constant 1 is sel 0 with inv 1.
- Node value = MAJ(a,b,c) = ab | ac | bc.
- Node table is a register array, cleared to all-zero by rst.
- FSM states: IDLE, EVAL, DONE. Reset state is IDLE.
- Reset values: in_ready=1, out_valid=0, out_bit=0, cfg_err=0, node results=0.
- IDLE:
  - in_ready=1.
  - On in_valid, latch in_x and in_len, clear all node results to 0, set idx=0.
  - Go to EVAL if in_len>0, else go to DONE with out_bit=0.
- EVAL:
  - in_ready=0.
  - Each cycle compute node[idx] from the latched vector and current node results, register it, and increment idx.
  - When idx==in_len-1, go to DONE.
  - A forward or self reference reads the current register value, which is 0 because results are cleared at accept.
- DONE:
  - out_valid=1; out_bit is held stable until the handshake.
  - On out_ready, go to IDLE.
  - No bypass: a new vector is accepted no earlier than the cycle after the output handshake.
- Latency: accept in cycle T gives out_valid in cycle T+in_len+1 (T+1 when in_len==0).
- in_len>NUM_NODES is saturated to NUM_NODES at accept.
- Config writes:
  - Accepted only in IDLE.
  - A cfg_we in EVAL/DONE is ignored and pulses cfg_err the next cycle.
  - If cfg_we and an input accept coincide in IDLE, the write takes effect and the evaluation uses the new entry.
- rst mid-evaluation aborts the evaluation and returns to the reset values; the node table is cleared too.

Optional Feature:
- Macro: MAJ_SWEEP_EN.
- When defined, the block adds these ports:
  - sweep_start in 1.
  - sweep_busy out 1.
  - sweep_done out 1 (one-cycle pulse).
  - sweep_count out NUM_IN+1.
- sweep_start in IDLE, using the current in_len:
  - Internally evaluates every vector 0..2^NUM_IN-1 in ascending order.
  - Counts the vectors with result 1, then pulses sweep_done with the count held until the next sweep_start.
  - During the sweep: in_ready=0, out_valid never asserts, and cfg writes raise cfg_err.
- sweep_start outside IDLE is ignored.
- When MAJ_SWEEP_EN is undefined, these ports are absent and the logic is not built.

Test Plan:
- Reset and idle: after rst, in_ready=1, out_valid=0. A cfg write to node 0 followed by accept with in_len=1, node0=MAJ(x0,x1,x2), in_x=7'b0000011 gives out_bit=1 exactly 2 cycles after accept.
- Five-node chain:
  - Program: n0=MAJ(x0,x4,x5), n1=MAJ(x1,x6,n0), n2=MAJ(x2,x3,n0), n3=MAJ(x0,x1,n1), n4=MAJ(x0,n2,n3), in_len=5.
  - in_x bits x0,x4 set -> out_bit=0.
  - in_x bits x0,x1 set -> out_bit=1.
  - All ones -> 1; all zeros -> 0; latency 6 cycles in each case.
- Complement/constants: node0 = MAJ(const1, x0, const0) -> out_bit follows x0. With x0 inverted -> out_bit=~x0. in_len=0 -> out_bit=0 at T+1.
- Backpressure/config guard:
  - Hold out_ready=0 for 10 cycles -> out_valid and out_bit stay stable and in_ready stays 0.
  - cfg_we during EVAL -> cfg_err pulses and the table is unchanged.
- Reset mid-operation and forward reference:
  - Assert rst during EVAL -> outputs return to reset values; a subsequent evaluation sees the cleared table.
  - node0 referencing node1 reads 0.
- MAJ_SWEEP_EN: node0=MAJ(x0,x1,x2), in_len=1, NUM_IN=7 -> sweep_count=64. Single node MAJ(const1,const1,x0) -> sweep_count=128.

Source files
------------

// File: rtl/maj_net_eval.sv
// maj_net_eval: programmable majority-of-three network evaluator, one node per cycle.
// Define MAJ_SWEEP_EN to build the exhaustive truth-table sweep counter.
module maj_net_eval #(
  parameter  int NUM_IN    = 7,
  parameter  int NUM_NODES = 8,
  parameter  int SEL_W     = $clog2(NUM_IN + NUM_NODES + 1),
  parameter  int LEN_W     = $clog2(NUM_NODES + 1),
  localparam int AW        = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1,
  localparam int OPW       = SEL_W + 1,
  localparam int CW        = 3 * OPW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [CW-1:0]     cfg_data,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_IN-1:0] in_x,
  input  logic [LEN_W-1:0]  in_len,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef MAJ_SWEEP_EN
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic [NUM_IN:0]   sweep_count,
`endif
  output logic              out_bit
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE, S_SNXT} state_t;

  state_t                r_state, w_next;
  logic [CW-1:0]         r_tbl [NUM_NODES];
  logic [NUM_NODES-1:0]  r_res;
  logic [NUM_IN-1:0]     r_x;
  logic [LEN_W-1:0]      r_len;
  logic [AW-1:0]         r_idx;
  logic                  r_out;
  logic                  r_cfg_err;

  logic [LEN_W-1:0]      w_len_sat;
  logic [CW-1:0]         w_entry;
  logic                  w_a, w_b, w_c, w_maj, w_last;

`ifdef MAJ_SWEEP_EN
  logic                  r_swp;
  logic                  r_sdone;
  logic [NUM_IN:0]       r_cnt;
`endif

  // Operand fetch: sel 0 and any unmapped sel read 0; inv applies after selection.
  function automatic logic f_opnd(input logic [OPW-1:0] op,
                                  input logic [NUM_IN-1:0] x,
                                  input logic [NUM_NODES-1:0] res);
    logic v;
    v = 1'b0;
    for (int k = 0; k < NUM_IN; k++)
      if (int'(op[SEL_W-1:0]) == k + 1) v = x[k];
    for (int k = 0; k < NUM_NODES; k++)
      if (int'(op[SEL_W-1:0]) == NUM_IN + 1 + k) v = res[k];
    return v ^ op[SEL_W];
  endfunction

  assign w_len_sat = (in_len > LEN_W'(NUM_NODES)) ? LEN_W'(NUM_NODES) : in_len;
  assign w_entry   = r_tbl[r_idx];
  assign w_a       = f_opnd(w_entry[OPW-1:0],       r_x, r_res);
  assign w_b       = f_opnd(w_entry[2*OPW-1:OPW],   r_x, r_res);
  assign w_c       = f_opnd(w_entry[3*OPW-1:2*OPW], r_x, r_res);
  assign w_maj     = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);
  assign w_last    = (LEN_W'(r_idx) == r_len - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_next = (w_len_sat == '0) ? S_DONE : S_EVAL;
`ifdef MAJ_SWEEP_EN
        else if (sweep_start) w_next = (w_len_sat == '0) ? S_SNXT : S_EVAL;
`endif
      end
      S_EVAL: begin
        if (w_last) begin
          w_next = S_DONE;
`ifdef MAJ_SWEEP_EN
          if (r_swp) w_next = S_SNXT;
`endif
        end
      end
      S_DONE: if (out_ready) w_next = S_IDLE;
`ifdef MAJ_SWEEP_EN
      S_SNXT: begin
        if (&r_x)                w_next = S_IDLE;
        else if (r_len != '0)    w_next = S_EVAL;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (r_state == S_IDLE);
    out_valid   = (r_state == S_DONE);
    out_bit     = (r_state == S_DONE) & r_out;
    cfg_err     = r_cfg_err;
`ifdef MAJ_SWEEP_EN
    sweep_busy  = r_swp;
    sweep_done  = r_sdone;
    sweep_count = r_cnt;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NUM_NODES; n++) r_tbl[n] <= '0;
      r_res     <= '0;
      r_x       <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_out     <= 1'b0;
      r_cfg_err <= 1'b0;
`ifdef MAJ_SWEEP_EN
      r_swp     <= 1'b0;
      r_sdone   <= 1'b0;
      r_cnt     <= '0;
`endif
    end else begin
      r_cfg_err <= 1'b0;
`ifdef MAJ_SWEEP_EN
      r_sdone   <= 1'b0;
`endif
      // Table writes only land while idle; an accept in the same cycle sees the new entry.
      if (cfg_we) begin
        if (r_state == S_IDLE && int'(cfg_addr) < NUM_NODES) r_tbl[cfg_addr] <= cfg_data;
        else r_cfg_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x   <= in_x;
            r_len <= w_len_sat;
            r_res <= '0;
            r_idx <= '0;
            r_out <= 1'b0;
          end
`ifdef MAJ_SWEEP_EN
          else if (sweep_start) begin
            r_x   <= '0;
            r_len <= w_len_sat;
            r_res <= '0;
            r_idx <= '0;
            r_out <= 1'b0;
            r_swp <= 1'b1;
            r_cnt <= '0;
          end
`endif
        end
        S_EVAL: begin
          r_res[r_idx] <= w_maj;
          r_idx        <= r_idx + AW'(1);
          if (w_last) r_out <= w_maj;
        end
`ifdef MAJ_SWEEP_EN
        S_SNXT: begin
          r_cnt <= r_cnt + (NUM_IN+1)'(r_out);
          if (&r_x) begin
            r_swp   <= 1'b0;
            r_sdone <= 1'b1;
          end else begin
            r_x   <= r_x + NUM_IN'(1);
            r_res <= '0;
            r_idx <= '0;
            r_out <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maj_net_eval.sv
// Scoreboard bench for maj_net_eval: driver pushes expected results, negedge monitor checks them.
`timescale 1ns/1ps
module tb_maj_net_eval;
  localparam int NUM_IN    = 7;
  localparam int NUM_NODES = 8;
  localparam int SEL_W     = $clog2(NUM_IN + NUM_NODES + 1);
  localparam int LEN_W     = $clog2(NUM_NODES + 1);
  localparam int AW        = $clog2(NUM_NODES);
  localparam int OPW       = SEL_W + 1;
  localparam int CW        = 3 * OPW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_we = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [CW-1:0]     cfg_data = '0;
  logic              cfg_err;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NUM_IN-1:0] in_x = '0;
  logic [LEN_W-1:0]  in_len = '0;
  logic              out_valid;
  logic              out_ready;
  logic              out_bit;
`ifdef MAJ_SWEEP_EN
  logic              sweep_start = 1'b0;
  logic              sweep_busy, sweep_done;
  logic [NUM_IN:0]   sweep_count;
`endif

  maj_net_eval #(.NUM_IN(NUM_IN), .NUM_NODES(NUM_NODES)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_len(in_len),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef MAJ_SWEEP_EN
    .sweep_start(sweep_start), .sweep_busy(sweep_busy),
    .sweep_done(sweep_done), .sweep_count(sweep_count),
`endif
    .out_bit(out_bit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;
  logic bp_hold = 1'b0;

  typedef struct { int acc; int len; logic b; } exp_t;
  exp_t sbq[$];
  exp_t cur;
  logic seen;

  logic [CW-1:0] mtbl [NUM_NODES];

  function automatic logic [OPW-1:0] op(input int inv, input int sel);
    return OPW'((inv << SEL_W) | sel);
  endfunction
  function automatic logic [CW-1:0] node(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                         input logic [OPW-1:0] c);
    return {c, b, a};
  endfunction
  function automatic int XS(input int k); return k + 1; endfunction
  function automatic int NS(input int j); return NUM_IN + 1 + j; endfunction
  function automatic int sat(input int len); return (len > NUM_NODES) ? NUM_NODES : len; endfunction

  // Reference: nodes in order, majority = at least two ones; untouched nodes read 0.
  function automatic logic model_eval(input logic [NUM_IN-1:0] x, input int len);
    int val [NUM_NODES];
    int ones, s, v;
    logic [OPW-1:0] o;
    for (int i = 0; i < NUM_NODES; i++) val[i] = 0;
    for (int i = 0; i < len; i++) begin
      ones = 0;
      for (int k = 0; k < 3; k++) begin
        o = mtbl[i][k*OPW +: OPW];
        s = int'(o[SEL_W-1:0]);
        v = 0;
        for (int j = 0; j < NUM_IN; j++) if (s == j + 1) v = x[j] ? 1 : 0;
        if (s > NUM_IN && s <= NUM_IN + NUM_NODES) v = val[s-NUM_IN-1];
        if (o[SEL_W]) v = 1 - v;
        ones += v;
      end
      val[i] = (ones >= 2) ? 1 : 0;
    end
    return (len == 0) ? 1'b0 : (val[len-1] != 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cfg_write(input int addr, input logic [CW-1:0] data);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_data = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    mtbl[addr] = data;
    @(negedge clk);
    chk("cfg_err_idle", cfg_err, 0);
  endtask

  task automatic send(input logic [NUM_IN-1:0] x, input int len, input int exp_ovr,
                      input bit do_cfg, input int caddr, input logic [CW-1:0] cdata);
    int g;
    exp_t e;
    @(posedge clk); #1;
    in_x = x; in_len = LEN_W'(len); in_valid = 1'b1;
    if (do_cfg) begin cfg_we = 1'b1; cfg_addr = AW'(caddr); cfg_data = cdata; end
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 300) begin g++; @(negedge clk); end
    if (!in_ready) begin
      checks++; fails++;
      $display("FAIL send_accept: in_ready stuck at %0d, required 1", in_ready);
      in_valid = 1'b0; cfg_we = 1'b0;
      return;
    end
    if (do_cfg) mtbl[caddr] = cdata;
    e.acc = cyc;
    e.len = sat(len);
    e.b   = (exp_ovr < 0) ? model_eval(x, e.len) : (exp_ovr != 0);
    sbq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while (!(sbq.size() == 0 && in_ready) && g < 500) begin g++; @(negedge clk); end
    if (g >= 500) begin
      checks++; fails++;
      $display("FAIL idle_wait: queue=%0d in_ready=%0d, required 0 and 1", sbq.size(), in_ready);
    end
  endtask

`ifdef MAJ_SWEEP_EN
  task automatic run_sweep(input string nm, input int exp_cnt);
    int g;
    @(posedge clk); #1;
    in_len = LEN_W'(1); sweep_start = 1'b1;
    @(posedge clk); #1;
    sweep_start = 1'b0;
    g = 0;
    @(negedge clk);
    chk({nm, "_rdy_low"}, in_ready, 0);
    while (!sweep_done && g < 5000) begin g++; @(negedge clk); end
    chk({nm, "_done"}, sweep_done, 1);
    chk(nm, sweep_count, exp_cnt);
  endtask
`endif

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency and value on the first valid cycle, stability until handshake.
  initial begin
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) seen = 1'b0;
      else if (out_valid) begin
        if (!seen) begin
          if (sbq.size() == 0) begin
            checks++; fails++;
            $display("FAIL out_unexpected: out_valid=1 with out_bit=%0d, no result outstanding", out_bit);
            cur.b = out_bit; cur.acc = cyc; cur.len = 0;
          end else begin
            cur = sbq.pop_front();
            chk("latency", cyc - cur.acc, cur.len + 1);
          end
          seen = 1'b1;
        end
        chk("out_bit", out_bit, cur.b);
        chk("in_ready_done", in_ready, 0);
        if (out_ready) seen = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("watchdog expired at cycle %0d", cyc);
    $fatal(1, "tb_maj_net_eval timeout");
  end

  initial begin
    int g;
    for (int n = 0; n < NUM_NODES; n++) mtbl[n] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_cfg_err", cfg_err, 0);

    // Single node MAJ(x0,x1,x2)
    cfg_write(0, node(op(0, XS(0)), op(0, XS(1)), op(0, XS(2))));
    send(7'b0000011, 1, 1, 0, 0, '0);
    wait_idle();

    // Five-node chain
    cfg_write(0, node(op(0, XS(0)), op(0, XS(4)), op(0, XS(5))));
    cfg_write(1, node(op(0, XS(1)), op(0, XS(6)), op(0, NS(0))));
    cfg_write(2, node(op(0, XS(2)), op(0, XS(3)), op(0, NS(0))));
    cfg_write(3, node(op(0, XS(0)), op(0, XS(1)), op(0, NS(1))));
    cfg_write(4, node(op(0, XS(0)), op(0, NS(2)), op(0, NS(3))));
    send(7'b0010001, 5, 0, 0, 0, '0);
    send(7'b0000011, 5, 1, 0, 0, '0);
    send(7'b1111111, 5, 1, 0, 0, '0);
    send(7'b0000000, 5, 0, 0, 0, '0);
    send(7'b1111111, 15, -1, 0, 0, '0);
    wait_idle();

    // Constants and complemented edges
    cfg_write(0, node(op(1, 0), op(0, XS(0)), op(0, 0)));
    send(7'b0000001, 1, 1, 0, 0, '0);
    send(7'b1111110, 1, 0, 0, 0, '0);
    wait_idle();
    cfg_write(0, node(op(1, 0), op(1, XS(0)), op(0, 0)));
    send(7'b0000001, 1, 0, 0, 0, '0);
    send(7'b0000000, 1, 1, 0, 0, '0);
    send(7'b1111111, 0, 0, 0, 0, '0);
    wait_idle();

    // Backpressure hold
    bp_hold = 1'b1;
    send(7'b0000000, 1, 1, 0, 0, '0);
    g = 0;
    @(negedge clk);
    while (!out_valid && g < 30) begin g++; @(negedge clk); end
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    bp_hold = 1'b0;
    wait_idle();

    // cfg write during EVAL is rejected
    cfg_write(0, node(op(0, XS(0)), op(0, XS(4)), op(0, XS(5))));
    send(7'b0000101, 5, 0, 0, 0, '0);
    cfg_we = 1'b1; cfg_addr = '0; cfg_data = node(op(1, 0), op(1, 0), op(1, 0));
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(negedge clk);
    chk("cfg_err_pulse", cfg_err, 1);
    @(negedge clk);
    chk("cfg_err_clear", cfg_err, 0);
    wait_idle();
    send(7'b0000101, 5, 0, 0, 0, '0);
    wait_idle();

    // Reset during evaluation
    send(7'b1111111, 5, -1, 0, 0, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    sbq.delete();
    for (int n = 0; n < NUM_NODES; n++) mtbl[n] = '0;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_bit", out_bit, 0);
    chk("midrst_cfg_err", cfg_err, 0);
    send(7'b1111111, 5, 0, 0, 0, '0);
    wait_idle();

    // Forward reference reads the cleared value
    cfg_write(1, node(op(1, 0), op(1, 0), op(1, 0)));
    cfg_write(0, node(op(1, NS(1)), op(0, XS(0)), op(0, 0)));
    send(7'b0000001, 2, 1, 0, 0, '0);
    send(7'b0000001, 1, 1, 0, 0, '0);
    send(7'b0000000, 1, 0, 0, 0, '0);
    wait_idle();

    // Write coinciding with accept is used by that evaluation
    send(7'b0000000, 1, 1, 1, 0, node(op(1, 0), op(1, 0), op(0, 0)));
    wait_idle();

    // Randomized table and vectors against the reference model
    for (int n = 0; n < NUM_NODES; n++) cfg_write(n, CW'($urandom));
    for (int i = 0; i < 60; i++) begin
      if (i % 6 == 0) begin
        wait_idle();
        send(NUM_IN'($urandom), $urandom_range(0, 15), -1, 1,
             $urandom_range(0, NUM_NODES-1), CW'($urandom));
      end else begin
        send(NUM_IN'($urandom), $urandom_range(0, 15), -1, 0, 0, '0);
      end
    end
    wait_idle();

`ifdef MAJ_SWEEP_EN
    cfg_write(0, node(op(0, XS(0)), op(0, XS(1)), op(0, XS(2))));
    run_sweep("sweep_maj3", 64);
    cfg_write(0, node(op(1, 0), op(1, 0), op(0, XS(0))));
    run_sweep("sweep_const1", 128);
    wait_idle();
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
